// File: rtl/psk_modem_param.sv
// Binary PSK modem: carrier modulator plus majority-vote coherent demodulator
// sharing one symbol/carrier timing base, with optional differential coding.
module psk_modem_param #(
  parameter int SYM_CYCLES  = 16,
  parameter int CARR_CYCLES = 4,
  parameter int DIFF        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic mod_out,
  input  logic rx_in,
  output logic rx_data,
  output logic rx_valid,
  output logic rx_amb
);

  localparam int CW = $clog2(CARR_CYCLES);
  localparam int SW = $clog2(SYM_CYCLES);
  localparam int AW = $clog2(SYM_CYCLES + 1);
  localparam logic [CW-1:0] CARR_LAST = CW'(CARR_CYCLES - 1);
  localparam logic [CW-1:0] CARR_HALF = CW'(CARR_CYCLES / 2);
  localparam logic [SW-1:0] SYM_LAST  = SW'(SYM_CYCLES - 1);
  localparam logic [AW-1:0] SYM_HALF  = AW'(SYM_CYCLES / 2);
  localparam bit DIFF_EN = (DIFF != 0);

  if (CARR_CYCLES < 2 || (CARR_CYCLES % 2) != 0 || SYM_CYCLES < 2 ||
      (SYM_CYCLES % 2) != 0 || (SYM_CYCLES % CARR_CYCLES) != 0) begin : g_param_check
    $error("psk_modem_param: illegal SYM_CYCLES/CARR_CYCLES combination");
  end

  logic [CW-1:0] carr_cnt;
  logic [SW-1:0] sym_cnt;
  logic [AW-1:0] acc;
  logic          e;
  logic          h_prev;

  logic          c;
  logic          boundary;
  logic          d;
  logic          m;
  logic [AW-1:0] tot;
  logic          h;
  logic          amb;

  assign c        = (carr_cnt < CARR_HALF);
  assign boundary = start && (sym_cnt == SYM_LAST);
  assign d        = tx_valid & tx_data;
  assign m        = rx_in ^ c;
  assign tot      = acc + AW'(m);
  assign h        = (tot > SYM_HALF);
  assign amb      = (tot == SYM_HALF);

  assign tx_ready = boundary;
  // Gated by rst_n so the line is quiet while reset is held, whatever start does.
  assign mod_out  = rst_n & start & (c ^ e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carr_cnt <= '0;
      sym_cnt  <= '0;
      acc      <= '0;
      e        <= 1'b0;
      h_prev   <= 1'b0;
      rx_data  <= 1'b0;
      rx_valid <= 1'b0;
      rx_amb   <= 1'b0;
    end else if (!start) begin
      // Idle: drop any partial symbol and restart coding from phase 0.
      carr_cnt <= '0;
      sym_cnt  <= '0;
      acc      <= '0;
      e        <= 1'b0;
      h_prev   <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      carr_cnt <= (carr_cnt == CARR_LAST) ? '0 : carr_cnt + 1'b1;
      sym_cnt  <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
      rx_valid <= 1'b0;
      if (boundary) begin
        e        <= DIFF_EN ? (e ^ d) : d;
        rx_data  <= DIFF_EN ? (h ^ h_prev) : h;
        h_prev   <= h;
        rx_amb   <= amb;
        rx_valid <= 1'b1;
        acc      <= '0;
      end else begin
        acc <= tot;
      end
    end
  end

endmodule
